sim_jtag_seq: RTL and testbench

Parametrised simulation JTAG master. It executes queued TAP commands (reset, IR scan, DR scan, idle) autonomously and returns captured TDO data over a ready/valid response channel. It replaces the host-driven, tick-by-tick JTAG driver in the testbench, so that debug-module benches run without host software. It sits in the testbench, driving the DUT's JTAG pins.

---
 rtl/sim_jtag_seq.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_sim_jtag_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_jtag_seq.sv
// sim_jtag_seq: testbench-side JTAG master. It runs queued TAP commands
// (TLR reset, IR scan, DR scan, idle) without host help and returns the
// captured TDO bits of each scan on a ready/valid response channel.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   enable              pauses the whole sequencer while low
//   init_done           sticky; commands are accepted only once it has been seen
//   cmd_*               command channel (op, len, TDI data, LSB shifted first)
//   rsp_*               scan result channel; bit i = i-th shifted TDO bit
//   cmd_count           completed commands (wraps)
//   jtag_TCK/TMS/TDI/TRSTn  TAP drive; jtag_TDO_data/_driven  TAP return
//
// Optional: define SIM_JTAG_RANDOM_TDO_EN to sample an undriven TDO as a
// random bit; otherwise an undriven TDO reads as 0.
module sim_jtag_seq #(
  parameter int unsigned TICK_DELAY = 50,
  parameter int unsigned MAX_LEN    = 64,
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               init_done,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic [31:0]        cmd_count,
  output logic               jtag_TCK,
  output logic               jtag_TMS,
  output logic               jtag_TDI,
  output logic               jtag_TRSTn,
  input  logic               jtag_TDO_data,
  input  logic               jtag_TDO_driven
);

  localparam int unsigned CNT_W = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
  localparam int unsigned CYC_W = LEN_W + 1;
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] OP_TLR  = 2'd0;
  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_DR   = 2'd2;
  localparam logic [1:0] OP_IDLE = 2'd3;

  // ST_RESP is the one clock between scan completion and rsp_valid
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESP} state_t;

  state_t             r_state, state_n;
  logic               r_reset;
  logic               r_init, init_n;
  logic [CNT_W-1:0]   r_cnt, cnt_n;
  logic               r_tck, tck_n;
  logic               r_tms, tms_n;
  logic               r_tdi, tdi_n;
  logic               r_trstn, trstn_n;
  logic [1:0]         r_op, op_n;
  logic [CYC_W-1:0]   r_len, len_n;
  logic [CYC_W-1:0]   r_total, total_n;
  logic [CYC_W-1:0]   r_cyc, cyc_n;
  logic [MAX_LEN-1:0] r_data, data_n;
  logic [MAX_LEN-1:0] r_cap, cap_n;
  logic               r_rsp_valid, rsp_valid_n;
  logic [MAX_LEN-1:0] r_rsp_data, rsp_data_n;
  logic [31:0]        r_count, count_n;
  logic               r_cmd_ready, cmd_ready_n;

  logic               w_rst;
  logic               w_run;
  logic               w_tick;
  logic               w_accept;
  logic               w_tdo;
  logic [LEN_W-1:0]   w_len_eff;
  logic [CYC_W-1:0]   w_total;
  logic [CYC_W-1:0]   w_cyc_inc;
  logic               w_last;
  logic               w_scan_op;

  // First shift cycle index: after SelDR/Capture/Shift entry (plus SelIR for IR)
  function automatic logic [CYC_W-1:0] f_s0(input logic [1:0] op);
    return (op == OP_IR) ? CYC_W'(4) : CYC_W'(3);
  endfunction

  function automatic logic f_shift(input logic [1:0] op, input logic [CYC_W-1:0] len,
                                   input logic [CYC_W-1:0] c);
    return ((op == OP_IR) || (op == OP_DR)) && (c >= f_s0(op)) && (c < f_s0(op) + len);
  endfunction

  // TMS for TCK cycle c of a command starting from Run-Test/Idle
  function automatic logic f_tms(input logic [1:0] op, input logic [CYC_W-1:0] len,
                                 input logic [CYC_W-1:0] c);
    logic t;
    t = 1'b0;
    case (op)
      OP_TLR:  t = (c < CYC_W'(6));
      OP_IDLE: t = 1'b0;
      default: begin
        if (c < f_s0(op))              t = (c == '0) || ((op == OP_IR) && (c == CYC_W'(1)));
        else if (c < f_s0(op) + len)   t = (c == f_s0(op) + len - CYC_W'(1));
        else                           t = (c == f_s0(op) + len);
      end
    endcase
    return t;
  endfunction

  function automatic logic f_tdi(input logic [1:0] op, input logic [CYC_W-1:0] len,
                                 input logic [MAX_LEN-1:0] data, input logic [CYC_W-1:0] c);
    logic [CYC_W-1:0] k;
    k = c - f_s0(op);
    return f_shift(op, len, c) ? data[IDX_W'(k)] : 1'b0;
  endfunction

  // Reset is stretched by one clock
  always_ff @(posedge clock) begin
    r_reset <= reset;
  end
  assign w_rst = reset || r_reset;

`ifdef SIM_JTAG_RANDOM_TDO_EN
  // Fresh random bit every clock models a floating TDO line
  logic r_float;
  always_ff @(posedge clock) begin
    r_float <= 1'($random);
  end
  assign w_tdo = jtag_TDO_driven ? jtag_TDO_data : r_float;
`else
  assign w_tdo = jtag_TDO_driven & jtag_TDO_data;
`endif

  // Scan lengths: 0 acts as 1, above MAX_LEN clamps; IDLE keeps the raw count
  always_comb begin
    w_len_eff = cmd_len;
    if ((cmd_op == OP_IR) || (cmd_op == OP_DR)) begin
      if (cmd_len == '0)                   w_len_eff = LEN_W'(1);
      else if (cmd_len > LEN_W'(MAX_LEN))  w_len_eff = LEN_W'(MAX_LEN);
    end
  end

  always_comb begin
    case (cmd_op)
      OP_TLR:  w_total = CYC_W'(7);
      OP_IR:   w_total = CYC_W'(w_len_eff) + CYC_W'(6);
      OP_DR:   w_total = CYC_W'(w_len_eff) + CYC_W'(5);
      default: w_total = CYC_W'(cmd_len);
    endcase
  end

  assign w_run     = enable && r_init && (r_state == ST_RUN);
  assign w_tick    = w_run && (r_cnt == '0);
  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_cyc_inc = r_cyc + CYC_W'(1);
  assign w_last    = (r_cyc == r_total - CYC_W'(1));
  assign w_scan_op = (r_op == OP_IR) || (r_op == OP_DR);

  // Next-state and next-output logic
  always_comb begin
    state_n     = r_state;
    init_n      = r_init | init_done;
    cnt_n       = r_cnt;
    tck_n       = r_tck;
    tms_n       = r_tms;
    tdi_n       = r_tdi;
    trstn_n     = r_trstn;
    op_n        = r_op;
    len_n       = r_len;
    total_n     = r_total;
    cyc_n       = r_cyc;
    data_n      = r_data;
    cap_n       = r_cap;
    rsp_valid_n = r_rsp_valid;
    rsp_data_n  = r_rsp_data;
    count_n     = r_count;

    case (r_state)
      ST_IDLE: begin
        if (r_rsp_valid && rsp_ready) rsp_valid_n = 1'b0;
        if (w_accept) begin
          op_n    = cmd_op;
          len_n   = CYC_W'(w_len_eff);
          total_n = w_total;
          cyc_n   = '0;
          data_n  = cmd_data;
          cap_n   = '0;
          cnt_n   = CNT_W'(TICK_DELAY);
          tck_n   = 1'b0;
          tms_n   = f_tms(cmd_op, CYC_W'(w_len_eff), '0);
          tdi_n   = f_tdi(cmd_op, CYC_W'(w_len_eff), cmd_data, '0);
          trstn_n = (cmd_op != OP_TLR);
          state_n = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_run) begin
          if (r_total == '0) begin
            // Zero-length IDLE: finish without any TCK activity
            count_n = r_count + 32'd1;
            tms_n   = 1'b0;
            tdi_n   = 1'b0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = (r_cnt == '0) ? CNT_W'(TICK_DELAY) : r_cnt - CNT_W'(1);
            if (w_tick) begin
              if (!r_tck) begin
                tck_n = 1'b1;
                if (f_shift(r_op, r_len, r_cyc))
                  cap_n[IDX_W'(r_cyc - f_s0(r_op))] = w_tdo;
              end else begin
                tck_n = 1'b0;
                if (w_last) begin
                  count_n = r_count + 32'd1;
                  tms_n   = 1'b0;
                  tdi_n   = 1'b0;
                  trstn_n = 1'b1;
                  state_n = w_scan_op ? ST_RESP : ST_IDLE;
                end else begin
                  cyc_n   = w_cyc_inc;
                  tms_n   = f_tms(r_op, r_len, w_cyc_inc);
                  tdi_n   = f_tdi(r_op, r_len, r_data, w_cyc_inc);
                  trstn_n = 1'b1;
                end
              end
            end
          end
        end
      end

      ST_RESP: begin
        rsp_valid_n = 1'b1;
        rsp_data_n  = r_cap;
        state_n     = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase

    cmd_ready_n = (state_n == ST_IDLE) && init_n && !rsp_valid_n;
  end

  // State register
  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_state     <= ST_IDLE;
      r_init      <= 1'b0;
      r_cnt       <= CNT_W'(TICK_DELAY);
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_trstn     <= 1'b1;
      r_op        <= OP_IDLE;
      r_len       <= '0;
      r_total     <= '0;
      r_cyc       <= '0;
      r_data      <= '0;
      r_cap       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= state_n;
      r_init      <= init_n;
      r_cnt       <= cnt_n;
      r_tck       <= tck_n;
      r_tms       <= tms_n;
      r_tdi       <= tdi_n;
      r_trstn     <= trstn_n;
      r_op        <= op_n;
      r_len       <= len_n;
      r_total     <= total_n;
      r_cyc       <= cyc_n;
      r_data      <= data_n;
      r_cap       <= cap_n;
      r_rsp_valid <= rsp_valid_n;
      r_rsp_data  <= rsp_data_n;
      r_count     <= count_n;
      r_cmd_ready <= cmd_ready_n;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign cmd_count  = r_count;
  assign jtag_TCK   = r_tck;
  assign jtag_TMS   = r_tms;
  assign jtag_TDI   = r_tdi;
  assign jtag_TRSTn = r_trstn;

endmodule

// File: tb/tb_sim_jtag_seq.sv
// Bench for sim_jtag_seq with TICK_DELAY=1 (4 clocks per TCK period), MAX_LEN=64.
module tb_sim_jtag_seq;
  localparam int unsigned ML = 64;
  localparam int unsigned LW = 7;

  logic          clock = 1'b0;
  logic          reset, enable, init_done, cmd_valid, rsp_ready;
  logic [1:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic [ML-1:0] cmd_data;
  logic          cmd_ready, rsp_valid;
  logic [ML-1:0] rsp_data;
  logic [31:0]   cmd_count;
  logic          jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic          tdo_data, tdo_driven;
  int            tdo_mode = 0;   // 0 loop TDI, 1 undriven (data=1), 2 driven constant 1

  assign tdo_data   = (tdo_mode == 0) ? jtag_TDI : 1'b1;
  assign tdo_driven = (tdo_mode != 1);

  sim_jtag_seq #(.TICK_DELAY(1), .MAX_LEN(ML)) dut (
    .clock(clock), .reset(reset), .enable(enable), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .cmd_count(cmd_count),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI),
    .jtag_TRSTn(jtag_TRSTn), .jtag_TDO_data(tdo_data),
    .jtag_TDO_driven(tdo_driven)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // TCK monitor: TMS at every rising TCK, TRSTn-low clocks, clock counter
  int           tck_edges = 0;
  int           trst_low = 0;
  logic [127:0] tms_log = '0;
  logic         prev_tck = 1'b0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic [31:0]  model_count = 0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (jtag_TCK && !prev_tck) begin
      if (tck_edges < 128) tms_log[7'(tck_edges)] = jtag_TMS;
      tck_edges++;
    end
    if (!jtag_TRSTn) trst_low++;
    prev_tck = jtag_TCK;
  end

  typedef struct {
    logic [1:0]    op;
    logic [LW-1:0] len;
    logic [ML-1:0] data;
    int            mode;
    int            periods;
    bit            has_rsp;
    logic [ML-1:0] rsp;
    int            trst;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int eff_len(input logic [1:0] op, input logic [LW-1:0] len);
    if (op == 2'd1 || op == 2'd2) begin
      if (len == 0) return 1;
      if (len > 7'(ML)) return ML;
    end
    return int'(len);
  endfunction

  // Expected TMS bit per TCK period, index = period number
  function automatic logic [127:0] exp_tms(input logic [1:0] op, input int n);
    logic [127:0] v;
    int p;
    v = '0;
    p = 3;
    case (op)
      2'd0: for (int i = 0; i < 6; i++) v[7'(i)] = 1'b1;
      2'd3: v = '0;
      default: begin
        v[0] = 1'b1;
        if (op == 2'd1) begin
          v[1] = 1'b1;
          p = 4;
        end
        v[7'(p + n - 1)] = 1'b1;
        v[7'(p + n)]     = 1'b1;
      end
    endcase
    return v;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [LW-1:0] len,
                       input logic [ML-1:0] data, input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " cmd_ready"}, 128'(cmd_ready), 128'(1'b1));
    tck_edges = 0;
    trst_low  = 0;
    tms_log   = '0;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int clocks);
    int n;
    n = 0;
    while (cmd_count == model_count && n < 2000) begin
      @(negedge clock);
      n++;
    end
    clocks = cyc - acc_cyc;
    model_count++;
    chk({tag, " cmd_count"}, 128'(cmd_count), 128'(model_count));
  endtask

  task automatic finish_rsp(input string tag, input bit has, input logic [ML-1:0] exp);
    int bad;
    bad = 0;
    @(negedge clock);
    chk({tag, " rsp_valid"}, 128'(rsp_valid), 128'(has));
    if (has) begin
      chk({tag, " rsp_data"}, 128'(rsp_data), 128'(exp));
      for (int i = 0; i < 5; i++) begin
        @(negedge clock);
        if (!(rsp_valid && !cmd_ready && rsp_data == exp)) bad++;
      end
      chk({tag, " rsp hold"}, 128'(bad), 128'(0));
      rsp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rsp_ready = 1'b0;
      chk({tag, " rsp release"}, 128'({rsp_valid, cmd_ready}), 128'(2'b01));
    end
  endtask

  task automatic wait_edges(input int target, input string tag);
    int n;
    n = 0;
    while (tck_edges < target && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " reached shift"}, 128'(tck_edges >= target), 128'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int clk_n;
    int bad;
    string tag;
    logic [36:0] snap;

    reset = 1'b1; enable = 1'b1; init_done = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'd0; cmd_len = '0; cmd_data = '0;

    //          op     len     data             mode per has rsp              trst
    vecs[0] = '{2'd0, 7'd0,   64'h0,            0,   7,  1'b0, 64'h0,            4};
    vecs[1] = '{2'd2, 7'd8,   64'hA5,           0,   13, 1'b1, 64'hA5,           0};
    vecs[2] = '{2'd1, 7'd5,   64'h11,           0,   11, 1'b1, 64'h11,           0};
    vecs[3] = '{2'd2, 7'd64,  {64{1'b1}},       0,   69, 1'b1, {64{1'b1}},       0};
    vecs[4] = '{2'd3, 7'd0,   64'h0,            0,   0,  1'b0, 64'h0,            0};
    vecs[5] = '{2'd3, 7'd3,   64'hFF,           0,   3,  1'b0, 64'h0,            0};
    vecs[6] = '{2'd2, 7'd100, {64{1'b1}},       1,   69, 1'b1, 64'h0,            0};
    vecs[7] = '{2'd2, 7'd0,   64'h1,            0,   6,  1'b1, 64'h1,            0};
    vecs[8] = '{2'd2, 7'd12,  64'h0,            2,   17, 1'b1, 64'hFFF,          0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset pins", 128'({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}), 128'(4'b0101));
    chk("reset handshake", 128'({cmd_ready, rsp_valid}), 128'(2'b00));
    chk("reset cmd_count", 128'(cmd_count), 128'(0));

    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (cmd_ready) bad++;
    end
    chk("ready before init_done", 128'(bad), 128'(0));
    init_done = 1'b1;
    @(negedge clock);
    chk("ready after init_done", 128'(cmd_ready), 128'(1'b1));

    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("v%0d", i);
      tdo_mode = vecs[i].mode;
      issue(vecs[i].op, vecs[i].len, vecs[i].data, tag);
      wait_done(tag, clk_n);
      chk({tag, " tck periods"}, 128'(tck_edges), 128'(vecs[i].periods));
      chk({tag, " clocks"}, 128'(clk_n),
          128'((vecs[i].periods == 0) ? 1 : 4 * vecs[i].periods));
      chk({tag, " tms seq"}, tms_log, exp_tms(vecs[i].op, eff_len(vecs[i].op, vecs[i].len)));
      chk({tag, " trst low clocks"}, 128'(trst_low), 128'(vecs[i].trst));
      finish_rsp(tag, vecs[i].has_rsp, vecs[i].rsp);
    end

    // enable held low for 20 clocks in the middle of a DR shift
    tdo_mode = 0;
    issue(2'd2, 7'd8, 64'h3C, "pause");
    wait_edges(6, "pause");
    enable = 1'b0;
    snap = {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, cmd_count, 1'b0};
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if ({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, cmd_count, 1'b0} !== snap) bad++;
    end
    chk("pause frozen", 128'(bad), 128'(0));
    enable = 1'b1;
    wait_done("pause", clk_n);
    chk("pause clocks", 128'(clk_n), 128'(52 + 20));
    chk("pause tck periods", 128'(tck_edges), 128'(13));
    chk("pause tms seq", tms_log, exp_tms(2'd2, 8));
    finish_rsp("pause", 1'b1, 64'h3C);

    // reset pulse in the middle of an IR scan, init_done dropped with it
    issue(2'd1, 7'd10, 64'h155, "abort");
    wait_edges(6, "abort");
    init_done = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort pins", 128'({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}), 128'(4'b0101));
    chk("abort handshake", 128'({cmd_ready, rsp_valid}), 128'(2'b00));
    chk("abort cmd_count", 128'(cmd_count), 128'(0));
    model_count = 0;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (cmd_ready || rsp_valid || jtag_TCK) bad++;
    end
    chk("abort quiet", 128'(bad), 128'(0));
    init_done = 1'b1;
    @(negedge clock);
    chk("abort ready after init", 128'(cmd_ready), 128'(1'b1));
    issue(2'd2, 7'd4, 64'h9, "recover");
    wait_done("recover", clk_n);
    chk("recover tck periods", 128'(tck_edges), 128'(9));
    finish_rsp("recover", 1'b1, 64'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
